// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
package seg_scan_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, 1 = lit
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // True when two or more select bits are set
    function automatic logic multi_hot(input logic [NUM_DIGITS-1:0] v);
        return |(v & (v - 6'd1));
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment pattern to digit value decoder.
// Define SEG_DECODE_HEX_EN to also decode the A-F patterns; otherwise they
// are reported as invalid.
module seg7_to_bcd
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       valid
);

    // Table lookup; unknown patterns yield 4'hF with valid low
    always_comb begin
        value = 4'hF;
        valid = 1'b0;
        case (seg)
            SEG_0: begin value = 4'h0; valid = 1'b1; end
            SEG_1: begin value = 4'h1; valid = 1'b1; end
            SEG_2: begin value = 4'h2; valid = 1'b1; end
            SEG_3: begin value = 4'h3; valid = 1'b1; end
            SEG_4: begin value = 4'h4; valid = 1'b1; end
            SEG_5: begin value = 4'h5; valid = 1'b1; end
            SEG_6: begin value = 4'h6; valid = 1'b1; end
            SEG_7: begin value = 4'h7; valid = 1'b1; end
            SEG_8: begin value = 4'h8; valid = 1'b1; end
            SEG_9: begin value = 4'h9; valid = 1'b1; end
`ifdef SEG_DECODE_HEX_EN
            SEG_A: begin value = 4'hA; valid = 1'b1; end
            SEG_B: begin value = 4'hB; valid = 1'b1; end
            SEG_C: begin value = 4'hC; valid = 1'b1; end
            SEG_D: begin value = 4'hD; valid = 1'b1; end
            SEG_E: begin value = 4'hE; valid = 1'b1; end
            SEG_F: begin value = 4'hF; valid = 1'b1; end
`else
`endif
            default: begin
                value = 4'hF;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers six digit values from a multiplexed seven-segment scan bus.
// A digit is captured once its select has been stable for SETTLE_CYC cycles;
// a full set of six captures publishes a frame on digits_out.
// Hex digit decoding is enabled by defining SEG_DECODE_HEX_EN.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     digit_sel_in,
    output logic [NUM_DIGITS*4-1:0]   digits_out,
    output logic                      frame_valid,
    output logic                      frame_strobe,
    output logic                      decode_err
);

    localparam int unsigned CW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYC);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);

    logic [6:0]              seg_r;
    logic [NUM_DIGITS-1:0]   sel_r;
    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [NUM_DIGITS-1:0]   lat_sel, lat_sel_nxt;
    logic                    capture;
    logic                    sel_multi, sel_onehot;
    logic [NUM_DIGITS-1:0]   bad_prev;
    logic [NUM_DIGITS-1:0]   seen, seen_nxt;
    logic                    frame_done;
    logic [NUM_DIGITS*4-1:0] shadow;
    logic [TW-1:0]           tmo;
    logic [3:0]              dec_value;
    logic                    dec_valid;

    seg7_to_bcd u_dec (
        .seg   (seg_r),
        .value (dec_value),
        .valid (dec_valid)
    );

    // Input registers: every downstream decision uses these copies
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= '0;
            sel_r <= '0;
        end else begin
            seg_r <= seg_in;
            sel_r <= digit_sel_in;
        end
    end

    always_comb begin
        sel_multi  = multi_hot(sel_r);
        sel_onehot = (|sel_r) && !sel_multi;
        frame_done = &seen;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            lat_sel <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            lat_sel <= lat_sel_nxt;
        end
    end

    // FSM next state: settle on a stable one-hot select, then capture once
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        lat_sel_nxt = lat_sel;
        capture     = 1'b0;
        case (state)
            S_IDLE: begin
                if (sel_onehot) begin
                    state_nxt   = S_SETTLE;
                    cnt_nxt     = CW'(1);
                    lat_sel_nxt = sel_r;
                end
            end
            S_SETTLE: begin
                if (sel_r != lat_sel) begin
                    if (sel_onehot) begin
                        state_nxt   = S_SETTLE;
                        cnt_nxt     = CW'(1);
                        lat_sel_nxt = sel_r;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (cnt == SETTLE_MAX) begin
                    state_nxt = S_CAPTURE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                capture   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame completion clears the seen set before this cycle's capture lands
    always_comb begin
        seen_nxt = frame_done ? '0 : seen;
        if (capture) begin
            seen_nxt = seen_nxt | lat_sel;
        end
    end

    // Capture datapath, frame publication and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            seen         <= '0;
            shadow       <= '0;
            digits_out   <= '0;
            frame_strobe <= 1'b0;
            decode_err   <= 1'b0;
            bad_prev     <= '0;
        end else begin
            seen         <= seen_nxt;
            frame_strobe <= frame_done;
            if (frame_done) begin
                digits_out <= shadow;
            end
            if (capture) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (lat_sel[i]) begin
                        shadow[i*4 +: 4] <= dec_value;
                    end
                end
            end
            // An illegal select held for many cycles reports only once
            decode_err <= (capture && !dec_valid) ||
                          (sel_multi && (sel_r != bad_prev));
            bad_prev   <= sel_multi ? sel_r : '0;
        end
    end

    // Frame age tracking; frame_valid drops as the counter saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo         <= '0;
            frame_valid <= 1'b0;
        end else if (frame_done) begin
            tmo         <= '0;
            frame_valid <= 1'b1;
        end else if (tmo != TMO_MAX) begin
            tmo <= tmo + 1'b1;
            if (tmo == TMO_LAST) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned TMO    = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = '0;
    logic [5:0]  digit_sel_in = '0;
    logic [23:0] digits_out;
    logic        frame_valid;
    logic        frame_strobe;
    logic        decode_err;

    seg_scan_decoder #(
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seg_in       (seg_in),
        .digit_sel_in (digit_sel_in),
        .digits_out   (digits_out),
        .frame_valid  (frame_valid),
        .frame_strobe (frame_strobe),
        .decode_err   (decode_err)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int strobe_cnt = 0;
    int err_cnt    = 0;
    int strobe_cyc = 0;
    int fall_cyc   = 0;
    logic fall_seen  = 1'b0;
    logic valid_prev = 1'b0;

    // Event monitor sampled on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frame_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_cyc = cyc;
        end
        if (decode_err) err_cnt = err_cnt + 1;
        if (valid_prev && !frame_valid) begin
            fall_cyc  = cyc;
            fall_seen = 1'b1;
        end
        valid_prev = frame_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show(input int idx, input logic [6:0] p, input int n);
        logic [5:0] s;
        s = '0;
        s[idx] = 1'b1;
        digit_sel_in = s;
        seg_in = p;
        tick(n);
    endtask

    task automatic blank(input int n);
        digit_sel_in = '0;
        seg_in = '0;
        tick(n);
    endtask

    int e0;
    int s0;
    logic [3:0] exp_nib0;
    int exp_err;

    initial begin
        // Reset state
        rst = 1'b1;
        tick(3);
        check("rst_digits", 32'(digits_out), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_strobe", 32'(frame_strobe), 32'h0);
        check("rst_err", 32'(decode_err), 32'h0);
        rst = 1'b0;
        tick(2);

        // Scan "123456", 10 cycles per digit
        for (int i = 0; i < 6; i++) show(i, pat[6-i], 10);
        blank(5);
        check("scan_strobes", 32'(strobe_cnt), 32'd1);
        check("scan_digits", 32'(digits_out), 32'h123456);
        check("scan_valid", 32'(frame_valid), 32'h1);
        check("scan_no_err", 32'(err_cnt), 32'd0);
        check("scan_seen_clr", 32'(dut.seen), 32'h0);

        // Select held too briefly to settle
        e0 = err_cnt;
        show(0, pat[6], 3);
        blank(8);
        check("short_seen", 32'(dut.seen), 32'h0);
        check("short_no_err", 32'(err_cnt - e0), 32'd0);

        // Illegal selects: one pulse per distinct value
        e0 = err_cnt;
        digit_sel_in = 6'b000011;
        seg_in = pat[1];
        tick(5);
        blank(3);
        check("multi_err_once", 32'(err_cnt - e0), 32'd1);
        check("multi_seen", 32'(dut.seen), 32'h0);
        digit_sel_in = 6'b110000;
        tick(3);
        blank(3);
        check("multi_err_second", 32'(err_cnt - e0), 32'd2);

        // Timeout with select held at zero
        check("tmo_still_valid", 32'(frame_valid), 32'h1);
        for (int k = 0; k < 400 && !fall_seen; k++) tick(1);
        check("tmo_fell", 32'(fall_seen), 32'h1);
        check("tmo_latency", 32'(fall_cyc - strobe_cyc), 32'(TMO));
        check("tmo_valid", 32'(frame_valid), 32'h0);
        check("tmo_digits_kept", 32'(digits_out), 32'h123456);

        // Pattern 0x77 on digit 0, then remaining digits 7,8,9,0,1
`ifdef SEG_DECODE_HEX_EN
        exp_nib0 = 4'hA;
        exp_err  = 0;
`else
        exp_nib0 = 4'hF;
        exp_err  = 1;
`endif
        s0 = strobe_cnt;
        e0 = err_cnt;
        show(0, 7'h77, 10);
        blank(2);
        check("hexA_err", 32'(err_cnt - e0), 32'(exp_err));
        check("hexA_seen", 32'(dut.seen), 32'h01);
        show(1, pat[7], 10);
        show(2, pat[8], 10);
        show(3, pat[9], 10);
        show(4, pat[0], 10);
        show(5, pat[1], 10);
        blank(3);
        check("hexA_strobe", 32'(strobe_cnt - s0), 32'd1);
        check("hexA_digits", 32'(digits_out), {8'h0, 20'h10987, exp_nib0});
        check("hexA_valid", 32'(frame_valid), 32'h1);

        // Reset after three captures discards the partial frame
        s0 = strobe_cnt;
        show(0, pat[1], 10);
        show(1, pat[2], 10);
        show(2, pat[3], 10);
        blank(1);
        check("part_seen", 32'(dut.seen), 32'h07);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("part_rst_seen", 32'(dut.seen), 32'h0);
        check("part_rst_digits", 32'(digits_out), 32'h0);
        check("part_rst_valid", 32'(frame_valid), 32'h0);
        show(3, pat[4], 10);
        show(4, pat[5], 10);
        show(5, pat[6], 10);
        blank(5);
        check("part_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        check("part_seen_hi", 32'(dut.seen), 32'h38);
        show(0, pat[1], 10);
        show(1, pat[2], 10);
        show(2, pat[3], 10);
        blank(3);
        check("part_strobe", 32'(strobe_cnt - s0), 32'd1);
        check("part_digits", 32'(digits_out), 32'h654321);
        check("part_valid", 32'(frame_valid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
